vend_machine_param: RTL and testbench

VEND_MACHINE_PARAM -- requirements
Module: vend_machine_param

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_change_out.sv | 44 ++++
 rtl/vend_machine_param.sv | 122 ++++++++++++
 tb/tb_vend_machine_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared encodings, FSM states and the coin-to-units mapping for the vending machine.
// Build with VEND_CANCEL_EN defined to add the REFUND state.
package vend_pkg;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_FIVE   = 2'b01;
    localparam logic [1:0] COIN_TEN    = 2'b10;
    localparam logic [1:0] COIN_TWENTY = 2'b11;

    localparam logic [1:0] BACK_NONE = 2'b00;
    localparam logic [1:0] BACK_FIVE = 2'b01;
    localparam logic [1:0] BACK_TEN  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE
`ifdef VEND_CANCEL_EN
        , ST_REFUND
`endif
    } state_t;

    // Value of one coin in 5-unit steps.
    function automatic logic [2:0] coin_units(input logic [1:0] c);
        case (c)
            COIN_FIVE:   coin_units = 3'd1;
            COIN_TEN:    coin_units = 3'd2;
            COIN_TWENTY: coin_units = 3'd4;
            default:     coin_units = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_out.sv
// Remaining-change counter and back-coin generator, shared by change-giving and refund.
// A step pays a ten while two or more units remain, otherwise a five; back is registered.
module vend_change_out
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                step,
    output logic [1:0]          back,
    output logic                last
);

    logic [CREDIT_W-1:0] rem;
    logic                ge2;

    assign ge2  = 32'(rem) >= 2;
    // The step taken while this is high empties the counter.
    assign last = 32'(rem) <= 2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            back <= BACK_NONE;
        end else if (load) begin
            rem  <= load_val;
            back <= BACK_NONE;
        end else if (step && rem != '0) begin
            if (ge2) begin
                back <= BACK_TEN;
                rem  <= rem - CREDIT_W'(2);
            end else begin
                back <= BACK_FIVE;
                rem  <= rem - CREDIT_W'(1);
            end
        end else begin
            back <= BACK_NONE;
        end
    end

endmodule

// File: rtl/vend_machine_param.sv
// Parameterised coin-operated drink vendor: credit collection, dispense, change.
// Define VEND_CANCEL_EN to add the cancel port and the refund path.
module vend_machine_param
    import vend_pkg::*;
#(
    parameter int PRICE_UNITS = 3,
    parameter int CREDIT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
`ifdef VEND_CANCEL_EN
    input  logic                cancel,
`endif
    output logic                drink,
    output logic [1:0]          back,
    output logic                coin_rej,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);

    state_t              state;
    logic [CREDIT_W:0]   sum;
    logic                coin_acc;
    logic                refund_req;
    logic                chg_load;
    logic                chg_step;
    logic                chg_last;
    logic [CREDIT_W-1:0] chg_val;

    // The carry bit of the widened sum flags a coin that would overflow credit.
    assign sum      = {1'b0, credit} + (CREDIT_W+1)'(coin_units(coin));
    assign coin_acc = (coin != COIN_NONE) && !sum[CREDIT_W];

`ifdef VEND_CANCEL_EN
    assign refund_req = cancel && (state == ST_COLLECT);
    assign chg_step   = (state == ST_CHANGE) || (state == ST_REFUND);
`else
    assign refund_req = 1'b0;
    assign chg_step   = (state == ST_CHANGE);
`endif

    always_comb begin
        chg_load = 1'b0;
        chg_val  = '0;
        if (state == ST_VEND) begin
            chg_load = 1'b1;
            chg_val  = credit - PRICE;
        end else if (refund_req) begin
            chg_load = 1'b1;
            chg_val  = coin_acc ? sum[CREDIT_W-1:0] : credit;
        end
    end

    vend_change_out #(.CREDIT_W(CREDIT_W)) u_change_out (
        .clk      (clk),
        .rst      (rst),
        .load     (chg_load),
        .load_val (chg_val),
        .step     (chg_step),
        .back     (back),
        .last     (chg_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            credit   <= '0;
            drink    <= 1'b0;
            coin_rej <= 1'b0;
            busy     <= 1'b0;
        end else begin
            drink    <= 1'b0;
            coin_rej <= (coin != COIN_NONE) && (busy || !coin_acc);
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (refund_req) begin
`ifdef VEND_CANCEL_EN
                        credit <= '0;
                        state  <= ST_REFUND;
                        busy   <= 1'b1;
`endif
                    end else if (coin_acc) begin
                        credit <= sum[CREDIT_W-1:0];
                        if (sum[CREDIT_W-1:0] >= PRICE) begin
                            state <= ST_VEND;
                            drink <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_VEND: begin
                    credit <= '0;
                    if (credit != PRICE) begin
                        state <= ST_CHANGE;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
`ifdef VEND_CANCEL_EN
                ST_REFUND,
`endif
                ST_CHANGE: begin
                    if (chg_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_machine_param.sv
// Bench for vend_machine_param: two parameterisations driven in lockstep against a
// queue-based model of expected per-cycle outputs.
module tb_vend_machine_param;

`ifdef VEND_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;

    logic       drink_a, coin_rej_a, busy_a;
    logic [1:0] back_a;
    logic [3:0] credit_a;
    logic       drink_b, coin_rej_b, busy_b;
    logic [1:0] back_b;
    logic [2:0] credit_b;

    always #5 clk = ~clk;

    vend_machine_param #(.PRICE_UNITS(3), .CREDIT_W(4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .coin     (coin),
`ifdef VEND_CANCEL_EN
        .cancel   (cancel),
`endif
        .drink    (drink_a),
        .back     (back_a),
        .coin_rej (coin_rej_a),
        .busy     (busy_a),
        .credit   (credit_a)
    );

    vend_machine_param #(.PRICE_UNITS(7), .CREDIT_W(3)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .coin     (coin),
`ifdef VEND_CANCEL_EN
        .cancel   (cancel),
`endif
        .drink    (drink_b),
        .back     (back_b),
        .coin_rej (coin_rej_b),
        .busy     (busy_b),
        .credit   (credit_b)
    );

    typedef struct {
        int drink;
        int back;
        int rej;
        int busy;
        int credit;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t cur [2];
    exp_t sq  [2][16];
    int   sl  [2];
    int   sp  [2];
    int   units [4] = '{0, 1, 2, 4};
    int   price [2] = '{3, 7};
    int   maxc  [2] = '{15, 7};

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t blank(input int cr);
        exp_t e;
        e.drink = 0; e.back = 0; e.rej = 0; e.busy = 0; e.credit = cr;
        return e;
    endfunction

    task automatic push(input int d, input exp_t e);
        sq[d][sl[d]] = e;
        sl[d]++;
    endtask

    // Queue the back-coin cycles that pay out amt, greedy tens then a five.
    task automatic push_payout(input int d, input int amt);
        int n;
        exp_t e;
        n = (amt + 1) / 2;
        for (int i = 0; i < n; i++) begin
            e = blank(0);
            e.back = (amt - 2 * i >= 2) ? 2 : 1;
            e.busy = (i < n - 1) ? 1 : 0;
            push(d, e);
        end
    endtask

    task automatic model_edge(input int d, input logic [1:0] c, input logic cn, input logic r);
        exp_t nx;
        int   tot;
        int   rej;
        if (r) begin
            cur[d] = blank(0);
            sl[d] = 0;
            sp[d] = 0;
            return;
        end
        rej = 0;
        if (sp[d] < sl[d]) begin
            nx = sq[d][sp[d]];
            sp[d]++;
            rej = (c != 0) ? 1 : 0;
        end else begin
            sl[d] = 0;
            sp[d] = 0;
            tot = cur[d].credit;
            if (c != 0) begin
                if (tot + units[c] > maxc[d]) rej = 1;
                else tot = tot + units[c];
            end
            nx = blank(tot);
            if (CANCEL_EN && cn && cur[d].credit > 0) begin
                nx.credit = 0;
                nx.busy = 1;
                push_payout(d, tot);
            end else if (tot >= price[d]) begin
                nx.drink = 1;
                nx.busy = 1;
                push(d, '{0, 0, 0, (tot > price[d]) ? 1 : 0, 0});
                push_payout(d, tot - price[d]);
            end
        end
        nx.rej = rej;
        cur[d] = nx;
    endtask

    task automatic cyc(input logic [1:0] c, input logic cn, input logic r);
        coin = c;
        cancel = cn;
        rst = r;
        @(posedge clk);
        model_edge(0, c, cn, r);
        model_edge(1, c, cn, r);
        #1;
        check("a.drink",  int'(drink_a),    cur[0].drink);
        check("a.back",   int'(back_a),     cur[0].back);
        check("a.rej",    int'(coin_rej_a), cur[0].rej);
        check("a.busy",   int'(busy_a),     cur[0].busy);
        check("a.credit", int'(credit_a),   cur[0].credit);
        check("b.drink",  int'(drink_b),    cur[1].drink);
        check("b.back",   int'(back_b),     cur[1].back);
        check("b.rej",    int'(coin_rej_b), cur[1].rej);
        check("b.busy",   int'(busy_b),     cur[1].busy);
        check("b.credit", int'(credit_b),   cur[1].credit);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cur[d] = blank(0);
            sl[d] = 0;
            sp[d] = 0;
        end
        // reset, including a coin on the reset edge
        cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b11, 1'b0, 1'b1);

        // five then ten: exact price, no change
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        idle(4);

        // ten then twenty: change of ten then five
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        idle(5);

        // coin during change is rejected
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        idle(4);

        // overflow rejection on the narrow instance
        cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 1'b0);
        idle(3);

        if (CANCEL_EN) begin
            cyc(2'b00, 1'b0, 1'b1);
            cyc(2'b10, 1'b0, 1'b0);
            cyc(2'b00, 1'b1, 1'b0);
            idle(3);
        end

        // reset in the first change cycle forfeits the change
        cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b10, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1);
        idle(3);

        for (int i = 0; i < 800; i++) begin
            logic [1:0] c;
            logic       cn;
            logic       r;
            c  = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            cn = CANCEL_EN && ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 59) == 0);
            cyc(c, cn, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
